// File: rtl/sync_filter.sv
// sync_filter: multi-bit CDC synchroniser with a per-bit stability filter and a change pulse.
// Define SYNC_FILTER_EDGE_EN to add the per-bit rise_o/fall_o edge-pulse outputs.
module sync_filter #(
    parameter int              WIDTH       = 1,
    parameter int              STAGES      = 2,
    parameter int              FILT_CYCLES = 4,
    parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             chg_o
`ifdef SYNC_FILTER_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
`endif
);

    localparam int               CNT_W   = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [WIDTH-1:0] upd;

    // NOTE: every stage of the chain is a reset flop, not a RAM, so the whole
    // array is cleared to RST_VAL; sequential state uses <= only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= data_i;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[STAGES-1];

    // NOTE: default assignment first so the loop can never leave a latch.
    always_comb begin
        upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upd[i] = (sync_s[i] != data_o[i]) && (cnt_q[i] == CNT_MAX);
        end
    end

    // A counter restarts whenever the level agrees again or has just been accepted,
    // so a short disagreement is discarded and the counter never passes CNT_MAX.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((sync_s[i] == data_o[i]) || upd[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o <= RST_VAL;
            chg_o  <= 1'b0;
        end else begin
            data_o <= (data_o & ~upd) | (sync_s & upd);
            chg_o  <= |upd;
        end
    end

`ifdef SYNC_FILTER_EDGE_EN
    // Edge pulses are registered alongside data_o so they coincide with its update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_o <= '0;
            fall_o <= '0;
        end else begin
            rise_o <= upd & sync_s;
            fall_o <= upd & ~sync_s;
        end
    end
`endif

endmodule

// File: doc/sync_filter.md
# sync_filter

Multi-bit clock-domain-crossing synchroniser with per-bit glitch filtering and optional edge-pulse outputs. It is the parametrised successor to the plain flip-flop sync chain and has a configurable chain depth and an asynchronous active-low reset to a programmable value. Each bit gets a stability counter, so a bit's output changes only after the synchronised input has held a new level for `FILT_CYCLES` consecutive cycles. It sits on asynchronous inputs of the measure unit: comparator strobes, external triggers and status lines.

## Interface
- `WIDTH`, 1: number of independent bit channels; must be ≥1.
- `STAGES`, 2: synchroniser flip-flop depth; must be ≥2.
- `FILT_CYCLES`, 4: number of consecutive cycles a new synchronised level must hold before it is accepted; must be ≥1.
- `RST_VAL`, '0: reset value of the sync chain and of `data_o`, `WIDTH` bits.

Ports (clock and reset first):
- `clk_i`  in  1  destination-domain clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `data_i`  in  WIDTH  asynchronous input bits.
- `data_o`  out  WIDTH  synchronised, filtered level.
- `chg_o`  out  1  one-cycle pulse when any bit of `data_o` changes.
- `rise_o`  out  WIDTH  per-bit one-cycle 0→1 pulse (only with `SYNC_FILTER_EDGE_EN`).
- `fall_o`  out  WIDTH  per-bit one-cycle 1→0 pulse (only with `SYNC_FILTER_EDGE_EN`).

## Operation
- **Sync chain:** `sync[1] <= data_i`, `sync[k] <= sync[k-1]`. Let `s = sync[STAGES]`.
- **Per-bit counter:** each bit `i` has counter `cnt[i]`, width `$clog2(FILT_CYCLES)` (minimum 1 bit).
- **Each edge, per bit:**
  - If `s[i] == data_o[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == FILT_CYCLES-1`: `data_o[i] <= s[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
- **Glitch rejection:** a disagreement shorter than `FILT_CYCLES` cycles clears the counter and is fully rejected. Counters never wrap and never exceed `FILT_CYCLES-1`.
- **`FILT_CYCLES=1`:** `data_o` follows `s` with one register of delay.
- **Independence:** bits are fully independent. Simultaneous changes on several bits are each filtered separately, so bits can update in different cycles after uneven skew.
- **`chg_o`:** registered. It is high in exactly the cycle `data_o` first shows a new value on at least one bit, and is a single pulse even when several bits change in the same cycle.
- **Reset (`rst_ni` low, immediate, also mid-operation):**
  - all `sync` stages and `data_o` go to `RST_VAL`;
  - `cnt` goes to 0;
  - `chg_o`, `rise_o` and `fall_o` go to 0.
  - No pulse is generated on reset entry or exit.
  - After reset release, an input differing from `RST_VAL` is treated as a normal change and produces pulses.

## Timing
- **Latency:** let edge k0 be the first edge that samples a stable new level. `data_o` shows it after edge `k0+STAGES+FILT_CYCLES-1`, i.e. `STAGES+FILT_CYCLES` cycles.
- **Acceptance threshold:** an input pulse held for G cycles (sampled G times) propagates iff G ≥ `FILT_CYCLES`.
- **Pulses:** `chg_o`, `rise_o` and `fall_o` are coincident with the `data_o` update cycle and always exactly one cycle wide.
- **Minimum spacing:** two accepted transitions on one bit are at least `FILT_CYCLES` cycles apart.
- **Combinational paths:** none from any input to any output; all outputs are flop-driven.

## Configuration
- **`SYNC_FILTER_EDGE_EN` defined:** `rise_o` and `fall_o` exist. `rise_o[i]` is set when `data_o[i]` goes 0→1; `fall_o[i]` is set when it goes 1→0.
- **Not defined:** the ports and their registers are absent; `chg_o` and `data_o` behaviour is unchanged.

## Test plan
All scenarios use `WIDTH=4`, `STAGES=2`, `FILT_CYCLES=3`, `RST_VAL=4'b0000`.
- **Reset:** hold `rst_ni`=0 with `data_i`=4'b1111 → `data_o`=0000 and all pulses 0 throughout. Release reset → `data_o`=1111 5 cycles later, `chg_o`=1 and `rise_o`=1111 for 1 cycle.
- **Latency:** step `data_i` 0000→0101 at edge k0 → `data_o`=0101 after edge k0+4. `rise_o`=0101 and `chg_o`=1 for that cycle only; `fall_o`=0000.
- **Glitch rejection:** bit2 pulsed high for 2 cycles → `data_o` unchanged and no pulses. Bit2 pulsed for 3 cycles → `data_o[2]` rises 4 cycles after its first sample, then falls 3 cycles later with `fall_o[2]` pulsing.
- **Skewed bits:** bit0 set at k0, bit3 set at k0+1 → `data_o[0]` after k0+4 and `data_o[3]` after k0+5, giving two separate `chg_o` pulses.
- **Async reset mid-filter:** assert `rst_ni` for 1 cycle while `cnt`=2 on bit1 → `data_o`=0000 immediately, counter cleared, and the subsequent update takes the full 5 cycles again.
- **Macro off:** build without `SYNC_FILTER_EDGE_EN` → `rise_o`/`fall_o` absent; rerun the latency scenario with identical `data_o` and `chg_o` results.
